// File: rtl/sha3_pad_stream.sv
// Streaming SHA3/SHAKE absorb padder: turns 64-bit message words into rate-aligned lanes
// carrying the domain suffix and pad10*1. Define SHA3_224_384_EN to enable modes 100/101.
module sha3_pad_stream #(
  parameter int unsigned MODE_W = 3,
  parameter int unsigned LANE_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              msg_valid_i,
  output logic              msg_ready_o,
  input  logic [LANE_W-1:0] msg_data_i,
  input  logic              msg_last_i,
  input  logic [3:0]        msg_keep_i,
  output logic              lane_valid_o,
  input  logic              lane_ready_i,
  output logic [LANE_W-1:0] lane_data_o,
  output logic [4:0]        lane_idx_o,
  output logic              block_last_o,
  output logic              msg_done_o,
  output logic [4:0]        rate_lanes_o,
  output logic              busy_o,
  output logic              err_o
);
  localparam int unsigned NBYTES = LANE_W / 8;
  localparam int unsigned IDX_W  = 5;

  if (LANE_W != 64) begin : g_lane_w_check
    $fatal(1, "sha3_pad_stream: LANE_W must be 64");
  end

  typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_PAD, S_FINAL} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rate_q, rate_d;
  logic [7:0]          dom_q, dom_d;
  logic                dpend_q, dpend_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                lv_q, lv_d;
  logic [LANE_W-1:0]   ldata_q, ldata_d;
  logic [IDX_W-1:0]    lidx_q, lidx_d;
  logic                lblk_q, lblk_d;
  logic                ldone_q, ldone_d;
  logic                err_q, err_d;

  logic                mode_ok;
  logic [IDX_W-1:0]    mode_rate;
  logic [7:0]          mode_dom;
  logic                load_ok;
  logic                lane_hs;
  logic                at_end;
  logic [IDX_W-1:0]    cnt_inc;

  // Keep bytes 0..keep-1 of the final word, place the domain byte at byte keep.
  function automatic logic [LANE_W-1:0] place_tail(input logic [LANE_W-1:0] data,
                                                    input logic [3:0] keep,
                                                    input logic [7:0] dom);
    logic [LANE_W-1:0] r;
    r = '0;
    for (int b = 0; b < int'(NBYTES); b++) begin
      if (4'(b) < keep) r[8*b +: 8] = data[8*b +: 8];
      else if (4'(b) == keep) r[8*b +: 8] = dom;
    end
    return r;
  endfunction

  always_comb begin
    mode_ok   = 1'b0;
    mode_rate = '0;
    mode_dom  = 8'h06;
    case (mode_i)
      3'b000: begin mode_ok = 1'b1; mode_rate = 5'd17; end
      3'b001: begin mode_ok = 1'b1; mode_rate = 5'd9;  end
      3'b010: begin mode_ok = 1'b1; mode_rate = 5'd21; mode_dom = 8'h1F; end
      3'b011: begin mode_ok = 1'b1; mode_rate = 5'd17; mode_dom = 8'h1F; end
`ifdef SHA3_224_384_EN
      3'b100: begin mode_ok = 1'b1; mode_rate = 5'd18; end
      3'b101: begin mode_ok = 1'b1; mode_rate = 5'd13; end
`endif
      default: ;
    endcase
  end

  assign load_ok = !lv_q || lane_ready_i;
  assign lane_hs = lv_q && lane_ready_i;
  assign at_end  = (cnt_q == rate_q - 5'd1);
  assign cnt_inc = at_end ? '0 : cnt_q + 5'd1;

  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    dom_d       = dom_q;
    dpend_d     = dpend_q;
    cnt_d       = cnt_q;
    lv_d        = lane_hs ? 1'b0 : lv_q;
    ldata_d     = ldata_q;
    lidx_d      = lidx_q;
    lblk_d      = lblk_q;
    ldone_d     = ldone_q;
    err_d       = 1'b0;
    msg_ready_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (mode_ok) begin
            rate_d  = mode_rate;
            dom_d   = mode_dom;
            cnt_d   = '0;
            dpend_d = 1'b0;
            state_d = S_ABSORB;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ABSORB: begin
        msg_ready_o = load_ok;
        if (msg_valid_i && load_ok) begin
          lv_d    = 1'b1;
          lidx_d  = cnt_q;
          lblk_d  = at_end;
          ldone_d = 1'b0;
          cnt_d   = cnt_inc;
          ldata_d = msg_data_i;
          if (msg_last_i) begin
            if (msg_keep_i >= 4'd8) begin
              dpend_d = 1'b1;
              state_d = S_PAD;
            end else begin
              ldata_d = place_tail(msg_data_i, msg_keep_i, dom_q);
              dpend_d = 1'b0;
              // Tail already ends the block: it becomes the final lane itself.
              if (at_end) begin
                ldata_d[LANE_W-1 -: 8] = ldata_d[LANE_W-1 -: 8] | 8'h80;
                ldone_d = 1'b1;
                state_d = S_FINAL;
              end else begin
                state_d = S_PAD;
              end
            end
          end
        end
      end
      S_PAD: begin
        if (load_ok) begin
          lv_d    = 1'b1;
          lidx_d  = cnt_q;
          lblk_d  = at_end;
          ldone_d = at_end;
          cnt_d   = cnt_inc;
          dpend_d = 1'b0;
          ldata_d = '0;
          if (dpend_q) ldata_d[7:0] = dom_q;
          if (at_end) begin
            ldata_d[LANE_W-1 -: 8] = ldata_d[LANE_W-1 -: 8] | 8'h80;
            state_d = S_FINAL;
          end
        end
      end
      S_FINAL: begin
        if (lane_hs && ldone_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rate_q  <= '0;
      dom_q   <= '0;
      dpend_q <= 1'b0;
      cnt_q   <= '0;
      lv_q    <= 1'b0;
      ldata_q <= '0;
      lidx_q  <= '0;
      lblk_q  <= 1'b0;
      ldone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      dom_q   <= dom_d;
      dpend_q <= dpend_d;
      cnt_q   <= cnt_d;
      lv_q    <= lv_d;
      ldata_q <= ldata_d;
      lidx_q  <= lidx_d;
      lblk_q  <= lblk_d;
      ldone_q <= ldone_d;
      err_q   <= err_d;
    end
  end

  assign lane_valid_o = lv_q;
  assign lane_data_o  = ldata_q;
  assign lane_idx_o   = lidx_q;
  assign block_last_o = lblk_q;
  assign msg_done_o   = ldone_q;
  assign rate_lanes_o = rate_q;
  assign busy_o       = (state_q != S_IDLE);
  assign err_o        = err_q;
endmodule

// File: doc/sha3_pad_stream.md
# sha3_pad_stream

Streaming absorb-side padder for the Keccak engine. Latches a hash mode at message start and accepts 64-bit message words over a valid/ready handshake. Emits rate-aligned 64-bit lanes with lane index and block boundary flags, appending the domain-separation suffix and pad10*1 so the permutation core only ever sees full rate blocks. It sits between the host message interface and the state-absorb XOR stage, and generalises the mode/rate table to six modes.

## Interface
- MODE_W, 3: mode select width; 000 SHA3-256, 001 SHA3-512, 010 SHAKE128, 011 SHAKE256, 100 SHA3-224, 101 SHA3-384.
- LANE_W, 64: lane and message word width. Fixed at 64 in this generation; any other value is a fatal elaboration error.
- clk_i  in  1  clock. One clock; reset is synchronous and active-low.
- rst_ni  in  1  synchronous active-low reset.
- start_i  in  1  single-cycle message start; sampled only in IDLE.
- mode_i  in  MODE_W  mode, sampled with start_i.
- msg_valid_i / msg_ready_o  in/out  1  message word handshake.
- msg_data_i  in  LANE_W  message word, little-endian bytes (byte 0 = bits 7:0).
- msg_last_i  in  1  final message word.
- msg_keep_i  in  4  valid byte count 0..8 of the final word; ignored when msg_last_i=0.
- lane_valid_o / lane_ready_i  out/in  1  lane handshake.
- lane_data_o  out  LANE_W  padded lane.
- lane_idx_o  out  5  lane index within the block, 0..rate_lanes-1.
- block_last_o  out  1  the current lane is lane rate_lanes-1.
- msg_done_o  out  1  the current lane is the final lane of the message.
- rate_lanes_o  out  5  latched rate in lanes.
- busy_o  out  1  state ≠ IDLE.
- err_o  out  1  one-cycle pulse on a rejected start.

## Operation
- Rate lanes: 256→17, 512→9, SHAKE128→21, SHAKE256→17, 224→18, 384→13. Domain byte D: 0x06 for SHA3 modes, 0x1F for SHAKE modes.
- States:
  - IDLE: on start_i with a legal mode, latch mode, rate and D, clear lane counter → ABSORB. On an illegal mode (110/111, or 1xx when the macro is off), pulse err_o and stay in IDLE.
  - ABSORB: msg_ready_o = !lane_valid_o || lane_ready_i.
    - A non-last word is registered as a lane unchanged.
    - A last word with keep<8 is registered as data bytes 0..keep-1, D at byte keep, zeros above → PAD.
    - A last word with keep=8 is registered unchanged; D is still pending → PAD.
  - PAD: emits the remaining lanes up to block end.
    - Byte 0 = D if D is pending; otherwise zero.
    - The lane at index rate_lanes-1 ORs 0x80 into byte 7. D and 0x80 combine into 0x86/0x9F when they coincide.
    - If D was pending at lane index 0, a full extra block is produced.
    - A lane with last=1 that ends a block with D already placed is itself the final lane (0x80 ORed in); PAD is then skipped.
  - The final lane is accepted (valid&&ready with msg_done_o) → IDLE.
- Lane counter: increments on each lane handshake; wraps to 0 after rate_lanes-1.
- msg_ready_o is 0 outside ABSORB. start_i is ignored when busy.

## Timing
- Reset: lane_valid_o, msg_ready_o, lane_data_o, lane_idx_o, block_last_o, msg_done_o, rate_lanes_o, busy_o and err_o are all 0; state is IDLE.
- start_i at cycle N → busy_o=1 and msg_ready_o=1 at N+1.
- Latency: a word accepted at edge N is presented on lane_data_o from N+1. Full throughput is one lane per cycle.
- lane_data_o, lane_idx_o, block_last_o and msg_done_o hold stable while lane_valid_o=1 and lane_ready_i=0.
- busy_o drops the cycle after the final handshake. A new start_i is accepted from that cycle.
- rst_ni low at any point, including mid-block or with a lane stalled, returns to IDLE on that edge and drops the pending lane.

## Configuration
- SHA3_224_384_EN defined: modes 100/101 are legal with rates 18/13.
- Undefined: modes 100/101 are rejected (err_o pulse, no state change); the rate logic for them is absent.

## Test plan
- SHA3-256, single last word with keep=0, lane_ready_i=1 → 17 lanes. Lane 0 = 0x0000_0000_0000_0006, lanes 1..15 = 0, lane 16 = 0x8000_0000_0000_0000 with block_last_o=msg_done_o=1.
- SHA3-512, 9 full words, last keep=8 → 18 lanes. Lanes 0..8 = data, lane 9 = 0x06, lane 17 = 0x80<<56, msg_done_o only on lane 17.
- SHA3-512, 71-byte message (last keep=7) → 9 lanes. Lane 8 byte 7 = 0x86, msg_done_o on lane 8, no extra block.
- SHAKE128, 3 words, last keep=3, data 0x…AABBCC → lane 2 = 0x0000_0000_1FAA_BBCC, lane 20 = 0x80<<56. lane_ready_i held low 5 cycles mid-stream → outputs stable, msg_ready_o=0.
- mode_i=100 → with the macro, rate_lanes_o=18; without it, err_o pulses once and busy_o stays 0.
- rst_ni low during PAD at lane 7 → next cycle busy_o=0 and lane_valid_o=0. A following SHAKE256 run gives rate_lanes_o=17 and lane_idx_o starts at 0.
